pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-stage controller that decides each cycle whether the PC register updates and with which value.
- Arbitrates four next-PC sources: sequential PC+4, ID-stage jump, EX-stage branch, exception vector.
- Buffers a redirect that arrives while fetch is stalled, and drives the IF/ID flush signals.
- Sits beside the PC register; drives its write enable and data input, and reads back its current output.

Parameters:
- RESET_VEC, 32'h00400000, PC value loaded on the first cycle after reset.
- EXC_VEC, 32'h80000180, exception handler entry address.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset (sampled on posedge clk only)
- pc_cur  in  32  current PC register output
- fetch_stall  in  1  instruction memory not ready; PC must hold
- hazard_stall  in  1  load-use hazard; PC must hold
- jmp  in  1  ID-stage jump/jr resolved
- jmp_target  in  32  jump target
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  32  branch target
- exc_req  in  1  exception raised; single-cycle pulse
- exc_pc  in  32  PC of the faulting instruction
- next_pc  out  32  data input to the PC register
- pc_write  out  1  PC register write enable
- flush_if  out  1  squash IF/ID pipeline register
- flush_id  out  1  squash ID/EX pipeline register
- epc  out  32  captured exception PC (registered)
- pend_valid  out  1  a redirect is buffered (registered, for debug/verification)

Behaviour:
- States: BOOT, RUN, PEND. The state register and pend_target/pend_kind/epc are the only sequential state; next_pc, pc_write and flush_* are combinational from state and inputs.
- Reset (reset=1 at a posedge):
  - state<=BOOT, pend_valid<=0, epc<=0.
  - While in BOOT: next_pc=RESET_VEC, pc_write=1, flush_if=1, flush_id=1.
  - BOOT->RUN unconditionally after one cycle.
- Redirect selection, in priority order:
  - exc_req -> target EXC_VEC, flush_if=1, flush_id=1, epc<=exc_pc.
  - br_taken -> br_target, flush_if=1, flush_id=1.
  - jmp -> jmp_target, flush_if=1, flush_id=0.
  - Lower-priority redirects in the same cycle are discarded.
- RUN, no redirect:
  - next_pc = pc_cur + 4, wrapping modulo 2^32.
  - pc_write = ~(fetch_stall | hazard_stall).
- RUN, redirect, fetch_stall=0:
  - next_pc=target, pc_write=1; hazard_stall is overridden.
  - Flushes as listed above; stay in RUN.
- RUN, redirect, fetch_stall=1:
  - pc_write=0; latch pend_target/pend_kind; pend_valid<=1; ->PEND.
  - Flushes assert in the same cycle.
- PEND, fetch_stall=1:
  - pc_write=0; flush_if=1 every cycle.
  - A new exc_req replaces the buffer (target EXC_VEC, epc updated).
  - A new br_taken replaces a buffered jmp, never a buffered exception.
  - A new jmp is ignored.
- PEND, fetch_stall=0:
  - next_pc=pend_target, pc_write=1, flush_if=1.
  - Clear pend_valid; ->RUN.
  - A same-cycle exc_req takes precedence: it is applied directly and the buffer is cleared.
- Alignment: bits [1:0] of next_pc are always forced to 00, for every source.
- Reset in any state or mid-PEND: the buffer is discarded and the BOOT sequence repeats.
- One redirect is applied per cycle; the block never writes the PC twice for one event.

Decomposition:
- Shared cpu package:
  - state enum {BOOT, RUN, PEND}.
  - pend_kind enum {PK_JMP, PK_BR, PK_EXC}.
  - RESET_VEC and EXC_VEC constants, shared with the CP0 logic.
- One sub-module: pc_redirect_mux, a combinational priority select producing target, kind and flush pair.
- The FSM and buffer stay in pc_sequencer.

Test Plan:
- Reset, then run 3 cycles with no stalls and pc_cur following next_pc -> cycle 1: next_pc=0x00400000, pc_write=1, both flushes=1; then 0x00400004, 0x00400008 with flushes=0.
- RUN, pc_cur=0x00400010, hazard_stall=1 for 2 cycles -> pc_write=0 both cycles; next cycle pc_write=1, next_pc=0x00400014.
- br_taken=1 (br_target=0x00400100) and jmp=1 (0x00400200) together -> next_pc=0x00400100, flush_if=1, flush_id=1; jump dropped.
- fetch_stall=1 and jmp=1 (0x00400040) -> pc_write=0, pend_valid=1. Two cycles later exc_req=1 with exc_pc=0x0040003C, still stalled -> buffer becomes EXC. After stall release: next_pc=0x80000180, pc_write=1, epc=0x0040003C, pend_valid=0.
- jmp_target=0x00400043 with no stall -> next_pc=0x00400040.
- pc_cur=0xFFFFFFFC, no events -> next_pc=0x00000000. Separately, reset asserted while PEND -> pend_valid=0 and next cycle next_pc=0x00400000.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage types and constants for the PC sequencer and CP0 logic.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PK_JMP = 2'd0,
    PK_BR  = 2'd1,
    PK_EXC = 2'd2
  } pend_kind_e;

  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;

  // Instruction fetch is word aligned whatever the source of the address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and the surrounding pipeline.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        fetch_stall;
  logic        hazard_stall;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] epc;
  logic        pend_valid;

  modport slave (
    input  pc_cur, fetch_stall, hazard_stall, jmp, jmp_target,
           br_taken, br_target, exc_req, exc_pc,
    output next_pc, pc_write, flush_if, flush_id, epc, pend_valid
  );

  modport master (
    output pc_cur, fetch_stall, hazard_stall, jmp, jmp_target,
           br_taken, br_target, exc_req, exc_pc,
    input  next_pc, pc_write, flush_if, flush_id, epc, pend_valid
  );
endinterface

// File: rtl/pc_sequencer_redirect_mux.sv
// Priority select among exception, branch and jump redirects (exception highest).
module pc_redirect_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_ADDR = 32'h8000_0180
) (
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output pend_kind_e  redir_kind,
  output logic        redir_flush_if,
  output logic        redir_flush_id
);

  // Lower-priority requests in the same cycle are simply not selected.
  always_comb begin
    redir_valid    = 1'b0;
    redir_target   = 32'h0000_0000;
    redir_kind     = PK_JMP;
    redir_flush_if = 1'b0;
    redir_flush_id = 1'b0;
    if (exc_req) begin
      redir_valid    = 1'b1;
      redir_target   = EXC_ADDR;
      redir_kind     = PK_EXC;
      redir_flush_if = 1'b1;
      redir_flush_id = 1'b1;
    end else if (br_taken) begin
      redir_valid    = 1'b1;
      redir_target   = br_target;
      redir_kind     = PK_BR;
      redir_flush_if = 1'b1;
      redir_flush_id = 1'b1;
    end else if (jmp) begin
      redir_valid    = 1'b1;
      redir_target   = jmp_target;
      redir_kind     = PK_JMP;
      redir_flush_if = 1'b1;
      redir_flush_id = 1'b0;
    end else begin
      redir_valid    = 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: picks the next PC, drives the PC write enable and
// IF/ID flushes, and holds one redirect while instruction fetch is stalled.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = pc_sequencer_pkg::RESET_VEC,
  parameter logic [31:0] EXC_VEC   = pc_sequencer_pkg::EXC_VEC
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);
  import pc_sequencer_pkg::*;

  state_e      state_r, state_s;
  logic        pend_valid_r, pend_valid_s;
  logic [31:0] pend_target_r, pend_target_s;
  pend_kind_e  pend_kind_r, pend_kind_s;
  logic [31:0] epc_r, epc_s;

  logic [31:0] next_pc_raw_s;
  logic        pc_write_s, flush_if_s, flush_id_s;

  logic        redir_valid_s, redir_flush_if_s, redir_flush_id_s;
  logic [31:0] redir_target_s;
  pend_kind_e  redir_kind_s;

  pc_redirect_mux #(.EXC_ADDR(EXC_VEC)) u_redirect_mux (
    .exc_req        (bus.exc_req),
    .br_taken       (bus.br_taken),
    .br_target      (bus.br_target),
    .jmp            (bus.jmp),
    .jmp_target     (bus.jmp_target),
    .redir_valid    (redir_valid_s),
    .redir_target   (redir_target_s),
    .redir_kind     (redir_kind_s),
    .redir_flush_if (redir_flush_if_s),
    .redir_flush_id (redir_flush_id_s)
  );

  // State, redirect buffer and EPC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= BOOT;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
      pend_kind_r   <= PK_JMP;
      epc_r         <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      pend_valid_r  <= pend_valid_s;
      pend_target_r <= pend_target_s;
      pend_kind_r   <= pend_kind_s;
      epc_r         <= epc_s;
    end
  end

  // Next-state logic and combinational PC-register controls.
  always_comb begin
    state_s       = state_r;
    pend_valid_s  = pend_valid_r;
    pend_target_s = pend_target_r;
    pend_kind_s   = pend_kind_r;
    epc_s         = epc_r;
    next_pc_raw_s = bus.pc_cur + 32'd4;
    pc_write_s    = 1'b0;
    flush_if_s    = 1'b0;
    flush_id_s    = 1'b0;
    case (state_r)
      BOOT: begin
        next_pc_raw_s = RESET_VEC;
        pc_write_s    = 1'b1;
        flush_if_s    = 1'b1;
        flush_id_s    = 1'b1;
        state_s       = RUN;
      end
      RUN: begin
        if (redir_valid_s) begin
          next_pc_raw_s = redir_target_s;
          flush_if_s    = redir_flush_if_s;
          flush_id_s    = redir_flush_id_s;
          if (redir_kind_s == PK_EXC) begin
            epc_s = bus.exc_pc;
          end else begin
            epc_s = epc_r;
          end
          // A redirect overrides a hazard stall, but a fetch stall defers it.
          if (!bus.fetch_stall) begin
            pc_write_s = 1'b1;
          end else begin
            pc_write_s    = 1'b0;
            pend_valid_s  = 1'b1;
            pend_target_s = redir_target_s;
            pend_kind_s   = redir_kind_s;
            state_s       = PEND;
          end
        end else begin
          pc_write_s = ~(bus.fetch_stall | bus.hazard_stall);
        end
      end
      PEND: begin
        flush_if_s = 1'b1;
        if (bus.fetch_stall) begin
          pc_write_s    = 1'b0;
          next_pc_raw_s = pend_target_r;
          // Exceptions always win; a branch only displaces a buffered jump.
          if (redir_valid_s && ((redir_kind_s == PK_EXC) ||
              ((redir_kind_s == PK_BR) && (pend_kind_r != PK_EXC)))) begin
            pend_target_s = redir_target_s;
            pend_kind_s   = redir_kind_s;
            flush_id_s    = redir_flush_id_s;
            if (redir_kind_s == PK_EXC) begin
              epc_s = bus.exc_pc;
            end else begin
              epc_s = epc_r;
            end
          end else begin
            flush_id_s = 1'b0;
          end
        end else begin
          pc_write_s   = 1'b1;
          pend_valid_s = 1'b0;
          state_s      = RUN;
          if (bus.exc_req) begin
            next_pc_raw_s = EXC_VEC;
            flush_id_s    = 1'b1;
            epc_s         = bus.exc_pc;
          end else begin
            next_pc_raw_s = pend_target_r;
            flush_id_s    = 1'b0;
          end
        end
      end
      default: begin
        next_pc_raw_s = RESET_VEC;
        pend_valid_s  = 1'b0;
        state_s       = BOOT;
      end
    endcase
  end

  assign bus.next_pc    = align_word(next_pc_raw_s);
  assign bus.pc_write   = pc_write_s;
  assign bus.flush_if   = flush_if_s;
  assign bus.flush_id   = flush_id_s;
  assign bus.epc        = epc_r;
  assign bus.pend_valid = pend_valid_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random traffic.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h8000_0180;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] np;
    logic        w;
    logic        fi;
    logic        fd;
    logic        pv;
    logic [31:0] epc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: boot flag, pending redirect (priority 3=exc, 2=br, 1=jmp), EPC, PC register.
  bit          m_known = 1'b0;
  bit          m_boot;
  bit          m_pend;
  int          m_pkind;
  logic [31:0] m_ptgt;
  logic [31:0] m_epc;
  logic [31:0] m_pc = 32'h0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  task automatic drive(input bit r, input bit fs, input bit hs,
                       input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt,
                       input bit e, input logic [31:0] ep,
                       input bit use_pc, input logic [31:0] pcv);
    exp_t        x;
    logic [31:0] pc, rt;
    int          rk;
    @(posedge clk);
    #1;
    cyc++;
    pc = use_pc ? pcv : m_pc;
    reset = r;
    bus.pc_cur = pc; bus.fetch_stall = fs; bus.hazard_stall = hs;
    bus.jmp = j; bus.jmp_target = jt; bus.br_taken = b; bus.br_target = bt;
    bus.exc_req = e; bus.exc_pc = ep;
    if (m_known) begin
      x.cyc = cyc; x.pv = m_pend; x.epc = m_epc;
      x.w = 1'b0; x.fi = 1'b0; x.fd = 1'b0; x.np = pc + 32'd4;
      rk = e ? 3 : (b ? 2 : (j ? 1 : 0));
      rt = e ? EV : (b ? bt : jt);
      if (m_boot) begin
        x.np = RV; x.w = 1'b1; x.fi = 1'b1; x.fd = 1'b1; m_boot = 1'b0;
      end else if (!m_pend) begin
        if (rk == 0) x.w = !(fs || hs);
        else begin
          x.np = rt; x.fi = 1'b1; x.fd = (rk >= 2);
          if (e) m_epc = ep;
          if (!fs) x.w = 1'b1;
          else begin m_pend = 1'b1; m_ptgt = rt; m_pkind = rk; end
        end
      end else if (fs) begin
        x.fi = 1'b1;
        if (rk == 3 || (rk == 2 && m_pkind != 3)) begin
          m_ptgt = rt; m_pkind = rk; x.fd = 1'b1;
          if (e) m_epc = ep;
        end
      end else begin
        x.w = 1'b1; x.fi = 1'b1; m_pend = 1'b0;
        if (e) begin x.np = EV; x.fd = 1'b1; m_epc = ep; end
        else x.np = m_ptgt;
      end
      x.np = {x.np[31:2], 2'b00};
      sb.push_back(x);
      if (x.w) m_pc = x.np;
    end
    if (r) begin
      m_known = 1'b1; m_boot = 1'b1; m_pend = 1'b0; m_epc = 32'h0;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("pc_write", x.cyc, {31'd0, bus.pc_write}, {31'd0, x.w});
      check("flush_if", x.cyc, {31'd0, bus.flush_if}, {31'd0, x.fi});
      check("flush_id", x.cyc, {31'd0, bus.flush_id}, {31'd0, x.fd});
      check("pend_valid", x.cyc, {31'd0, bus.pend_valid}, {31'd0, x.pv});
      check("epc", x.cyc, bus.epc, x.epc);
      check("next_pc_align", x.cyc, {30'd0, bus.next_pc[1:0]}, 32'h0);
      if (x.w) check("next_pc", x.cyc, bus.next_pc, x.np);
    end
  end

  initial begin
    bit last_e;
    bit e;
    bus.pc_cur = 32'h0; bus.fetch_stall = 1'b0; bus.hazard_stall = 1'b0;
    bus.jmp = 1'b0; bus.jmp_target = 32'h0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
    bus.exc_req = 1'b0; bus.exc_pc = 32'h0;

    // Boot sequence then sequential fetch.
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (3) idle();
    // Hazard stall holds the PC.
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0040_0010);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0040_0010);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0040_0010);
    // Branch beats a simultaneous jump.
    drive(0, 0, 0, 1, 32'h0040_0200, 1, 32'h0040_0100, 0, 32'h0, 0, 32'h0);
    idle();
    // Jump buffered under fetch stall, then replaced by an exception.
    drive(0, 1, 0, 1, 32'h0040_0040, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0040_003C, 0, 32'h0);
    idle();
    idle();
    // Misaligned jump target and PC wrap.
    drive(0, 0, 0, 1, 32'h0040_0043, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    // Reset while a redirect is pending.
    drive(0, 1, 0, 0, 32'h0, 1, 32'h0040_0300, 0, 32'h0, 0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    idle();
    idle();

    last_e = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      e = ($urandom_range(0, 19) == 0) && !last_e;
      last_e = e;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom,
            e, $urandom,
            $urandom_range(0, 49) == 0,
            ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : $urandom);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
